// File: rtl/t03_ibuf_pkg.sv
// Shared types and defaults for the instruction prefetch buffer.
package t03_ibuf_pkg;

    localparam int IBUF_WIDTH = 32;
    localparam int IBUF_AW    = 32;
    localparam int IBUF_DEPTH = 4;

    // Canonical NOP (addi x0,x0,0), reserved for future bubble insertion.
    localparam logic [31:0] IBUF_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [IBUF_AW-1:0]    addr;
        logic [IBUF_WIDTH-1:0] data;
    } ibuf_entry_t;

    // Source of the word presented to decode this cycle.
    typedef enum logic [1:0] {
        OUT_KILL   = 2'd0,  // flush or reset: nothing valid
        OUT_HOLD   = 2'd1,  // frozen: replay last presented word
        OUT_HEAD   = 2'd2,  // queue head
        OUT_BYPASS = 2'd3   // empty queue: fetch word straight through
    } out_sel_t;

    // Output source priority: kill > freeze > stored head > bypass.
    function automatic out_sel_t sel_output(input logic kill, input logic frz,
                                            input logic empty);
        if (kill)       return OUT_KILL;
        else if (frz)   return OUT_HOLD;
        else if (!empty) return OUT_HEAD;
        else            return OUT_BYPASS;
    endfunction

endpackage

// File: rtl/ibuf_storage.sv
// Entry storage for the prefetch buffer: one write port, asynchronous read.
module ibuf_storage
    import t03_ibuf_pkg::*;
#(
    parameter int W     = IBUF_WIDTH + IBUF_AW,
    parameter int DEPTH = IBUF_DEPTH,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_ptr,
    input  logic [W-1:0]  wr_data,
    input  logic [PW-1:0] rd_ptr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Write the incoming entry at the tail slot.
    // NOTE: the array has no reset; count gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch queue between fetch and decode with empty-queue bypass,
// freeze (replay last presented word) and flush (discard everything).
module instr_prefetch_buffer
    import t03_ibuf_pkg::*;
#(
    parameter int WIDTH = IBUF_WIDTH,
    parameter int AW    = IBUF_AW,
    parameter int DEPTH = IBUF_DEPTH,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_addr,
    output logic             in_ready,
    input  logic             freeze,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [AW-1:0]    out_addr,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = AW + WIDTH;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [EW-1:0]    head;
    logic             hold_valid;
    logic [WIDTH-1:0] hold_data;
    logic [AW-1:0]    hold_addr;

    logic     empty;
    logic     full;
    logic     bypass_take;
    logic     push;
    logic     pop;
    out_sel_t sel;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // in_ready deliberately ignores out_ready so there is no fetch<->decode combinational loop.
    assign in_ready    = ~full & ~flush;
    assign bypass_take = empty & in_valid & out_ready & ~freeze & ~flush;
    assign push        = in_valid & in_ready & ~bypass_take;
    assign pop         = out_valid & out_ready & ~freeze & ~flush & ~empty;

    // Outputs are forced idle while reset is asserted so bypass cannot leak a word.
    assign sel = sel_output(flush | ~rst_n, freeze, empty);

    ibuf_storage #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (clk),
        .wr_en   (push),
        .wr_ptr  (wr_ptr),
        .wr_data ({in_addr, in_data}),
        .rd_ptr  (rd_ptr),
        .rd_data (head)
    );

    // Select the word presented to decode; data/addr are zero whenever out_valid is low.
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_addr  = '0;
        case (sel)
            OUT_HOLD: begin
                out_valid = hold_valid;
                out_data  = hold_data;
                out_addr  = hold_addr;
            end
            OUT_HEAD: begin
                out_valid = 1'b1;
                out_data  = head[WIDTH-1:0];
                out_addr  = head[EW-1:WIDTH];
            end
            OUT_BYPASS: begin
                if (in_valid) begin
                    out_valid = 1'b1;
                    out_data  = in_data;
                    out_addr  = in_addr;
                end
            end
            default: ;
        endcase
    end

    // Queue pointers and occupancy; flush empties the queue in one edge.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Hold register snapshots the presented word on every unfrozen edge for replay during freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_addr  <= '0;
        end else if (flush) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_addr  <= '0;
        end else if (!freeze) begin
            hold_valid <= out_valid;
            hold_data  <= out_data;
            hold_addr  <= out_addr;
        end
    end

endmodule
